ntt_stage_scheduler: RTL and testbench

- Sequences the butterfly address/stride datapath through every stage of an N-point transform, with N = 16 << i_point_configuration.
- Issues LANES butterflies per accepted cycle and presents stage, stride, butterfly index and top address.
- Drains the PIPE_DEPTH-cycle datapath pipeline between stages, because the in-place memory must not be read before the previous stage's writes land.
- Sits between the top-level start/done control and the per-page address/stride logic.

---
 rtl/ntt_sched_pkg.sv | 27 ++
 rtl/ntt_stage_addr_gen.sv | 33 +++
 rtl/ntt_stage_scheduler.sv | 179 +++++++++++++++++
 tb/tb_ntt_stage_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_sched_pkg.sv
// ntt_sched_pkg: shared definitions for the NTT stage scheduler and the
// per-page address/stride generators.
//   state_e          scheduler FSM states
//   MAX_CFG          largest legal point configuration (N = 16 << 5 = 512)
//   BASE_LOG2N       log2 of the smallest transform (N = 16)
//   DEF_LANES        default butterflies issued per accepted cycle
//   DEF_PIPE_DEPTH   default datapath retire latency
//   stage_count()    number of stages for a configuration (log2 N)
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MAX_CFG        = 5;
  localparam int BASE_LOG2N     = 4;
  localparam int DEF_LANES      = 4;
  localparam int DEF_PIPE_DEPTH = 6;

  function automatic logic [3:0] stage_count(input logic [2:0] cfg);
    return 4'(BASE_LOG2N) + {1'b0, cfg};
  endfunction

endpackage

// File: rtl/ntt_stage_addr_gen.sv
// ntt_stage_addr_gen: combinational stride and top-operand address for one
// butterfly index. Shared between the scheduler and the datapath pages.
//   cfg_i       point configuration (N = 16 << cfg)
//   stage_i     current stage, 0..(3+cfg)
//   k_i         butterfly index
//   stride_o    (N/2) >> stage
//   addr_top_o  top operand address; the bottom operand is top + stride
module ntt_stage_addr_gen
  import ntt_sched_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [2:0]       cfg_i,
  input  logic [3:0]       stage_i,
  input  logic [IDX_W-1:0] k_i,
  output logic [IDX_W-1:0] stride_o,
  output logic [IDX_W-1:0] addr_top_o
);

  logic [3:0]       s;
  logic [IDX_W-1:0] mask;

  always_comb begin
    // log2 of the stride: (log2 N - 1) - stage
    s          = 4'(BASE_LOG2N - 1) + {1'b0, cfg_i} - stage_i;
    stride_o   = IDX_W'(1) << s;
    mask       = stride_o - IDX_W'(1);
    // Insert a zero bit at position s: the group number moves up one bit,
    // the offset within the group stays in place.
    addr_top_o = ((k_i >> s) << (s + 4'd1)) | (k_i & mask);
  end

endmodule

// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler: walks the butterfly datapath through every stage of an
// N-point transform (N = 16 << i_point_configuration), issuing LANES
// butterflies per accepted cycle and draining the PIPE_DEPTH-cycle datapath
// between stages so in-place reads never overtake the previous stage's writes.
// Ports:
//   clock, i_reset          rising-edge clock, async active-high reset
//   i_start, i_point_configuration  start request / size code (IDLE only)
//   i_abort                 synchronous abort back to IDLE
//   i_issue_ready           datapath accepts the current issue
//   o_busy, o_issue_valid   non-IDLE / issue fields valid
//   o_stage, o_stride, o_bfly_index, o_addr_top  issue fields
//   o_new_stage, o_last_issue  first / final issue of a stage
//   o_done, o_cfg_err       one-cycle completion / rejected-config pulses
//   o_stall_cycles          stall counter (NTT_SCHED_STALL_CNT_EN), else 0
// Optional feature macro: NTT_SCHED_STALL_CNT_EN
module ntt_stage_scheduler #(
  parameter int LANES      = ntt_sched_pkg::DEF_LANES,
  parameter int PIPE_DEPTH = ntt_sched_pkg::DEF_PIPE_DEPTH,
  parameter int IDX_W      = 10,
  parameter int MAX_CFG    = ntt_sched_pkg::MAX_CFG
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_point_configuration,
  input  logic             i_abort,
  input  logic             i_issue_ready,
  output logic             o_busy,
  output logic             o_issue_valid,
  output logic [3:0]       o_stage,
  output logic [IDX_W-1:0] o_stride,
  output logic [IDX_W-1:0] o_bfly_index,
  output logic [IDX_W-1:0] o_addr_top,
  output logic             o_new_stage,
  output logic             o_last_issue,
  output logic             o_done,
  output logic             o_cfg_err,
  output logic [15:0]      o_stall_cycles
);
  import ntt_sched_pkg::*;

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

  state_e           state_q, state_d;
  logic [2:0]       cfg_q, cfg_d;
  logic [3:0]       stage_q, stage_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_err_q, cfg_err_d;

  logic             busy, valid;
  logic [3:0]       last_stage;
  logic [IDX_W-1:0] last_k;
  logic [IDX_W-1:0] stride_w, top_w;

  assign busy       = (state_q != ST_IDLE);
  assign valid      = (state_q == ST_ISSUE);
  assign last_stage = stage_count(cfg_q) - 4'd1;
  // N/2 = 1 << (log2 N - 1); the final issue starts LANES below it
  assign last_k     = (IDX_W'(1) << last_stage) - IDX_W'(LANES);

  ntt_stage_addr_gen #(
    .IDX_W(IDX_W)
  ) u_addr_gen (
    .cfg_i     (cfg_q),
    .stage_i   (stage_q),
    .k_i       (k_q),
    .stride_o  (stride_w),
    .addr_top_o(top_w)
  );

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    stage_d   = stage_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // abort in IDLE suppresses both the start and the config check
        if (i_start && !i_abort) begin
          if (i_point_configuration <= 3'(MAX_CFG)) begin
            cfg_d   = i_point_configuration;
            stage_d = '0;
            k_d     = '0;
            state_d = ST_ISSUE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (i_issue_ready) begin
          if (k_q == last_k) begin
            cnt_d   = CNT_W'(PIPE_DEPTH);
            state_d = ST_DRAIN;
          end else begin
            k_d = k_q + IDX_W'(LANES);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (stage_q == last_stage) begin
            state_d = ST_DONE;
          end else begin
            stage_d = stage_q + 4'd1;
            k_d     = '0;
            state_d = ST_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      stage_q   <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      stage_q   <= stage_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Issue fields read as zero whenever the scheduler is idle.
  assign o_busy        = busy;
  assign o_issue_valid = valid;
  assign o_stage       = busy ? stage_q  : '0;
  assign o_stride      = busy ? stride_w : '0;
  assign o_bfly_index  = busy ? k_q      : '0;
  assign o_addr_top    = busy ? top_w    : '0;
  assign o_new_stage   = valid && (k_q == '0);
  assign o_last_issue  = valid && (k_q == last_k);
  assign o_done        = (state_q == ST_DONE);
  assign o_cfg_err     = cfg_err_q;

`ifdef NTT_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && (state_d == ST_ISSUE)) begin
      stall_d = '0;
    end else if (valid && !i_issue_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Directed bench for ntt_stage_scheduler. Inputs change and outputs are
// sampled on the falling edge; "j" is the number of rising edges since the
// edge that sampled the start request.
module tb_ntt_stage_scheduler;

  logic       clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic [2:0] i_point_configuration = 3'd0;
  logic       i_abort = 1'b0;
  logic       i_issue_ready = 1'b0;
  logic       o_busy, o_issue_valid, o_new_stage, o_last_issue, o_done, o_cfg_err;
  logic [3:0] o_stage;
  logic [9:0] o_stride, o_bfly_index, o_addr_top;
  logic [15:0] o_stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ntt_stage_scheduler dut (
    .clock                (clock),
    .i_reset              (i_reset),
    .i_start              (i_start),
    .i_point_configuration(i_point_configuration),
    .i_abort              (i_abort),
    .i_issue_ready        (i_issue_ready),
    .o_busy               (o_busy),
    .o_issue_valid        (o_issue_valid),
    .o_stage              (o_stage),
    .o_stride             (o_stride),
    .o_bfly_index         (o_bfly_index),
    .o_addr_top           (o_addr_top),
    .o_new_stage          (o_new_stage),
    .o_last_issue         (o_last_issue),
    .o_done               (o_done),
    .o_cfg_err            (o_cfg_err),
    .o_stall_cycles       (o_stall_cycles)
  );

  typedef struct {
    int         j;
    logic       v, b, d, f;
    logic [3:0] st;
    logic [9:0] sd, k, top;
    logic       ns, li;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int j, input logic v, b, d, f, input logic [3:0] st,
                     input logic [9:0] sd, k, top, input logic ns, li);
    vec_t r;
    r.j = j; r.v = v; r.b = b; r.d = d; r.f = f; r.st = st;
    r.sd = sd; r.k = k; r.top = top; r.ns = ns; r.li = li;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},   32'(o_busy), 0);
    chk({tag, ".valid"},  32'(o_issue_valid), 0);
    chk({tag, ".stage"},  32'(o_stage), 0);
    chk({tag, ".stride"}, 32'(o_stride), 0);
    chk({tag, ".k"},      32'(o_bfly_index), 0);
    chk({tag, ".top"},    32'(o_addr_top), 0);
    chk({tag, ".new"},    32'(o_new_stage), 0);
    chk({tag, ".last"},   32'(o_last_issue), 0);
    chk({tag, ".done"},   32'(o_done), 0);
    chk({tag, ".cfgerr"}, 32'(o_cfg_err), 0);
    chk({tag, ".stall"},  32'(o_stall_cycles), 0);
  endtask

  initial begin
    int   exp_stall;
    logic done_seen;

`ifdef NTT_SCHED_STALL_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif

    // cfg=0, ready held high: j, valid, busy, done, fields?, stage, stride, k, top, new, last
    add(1,  1, 1, 0, 1, 0, 8, 0, 0, 1, 0);
    add(2,  1, 1, 0, 1, 0, 8, 4, 4, 0, 1);
    add(3,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(8,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(9,  1, 1, 0, 1, 1, 4, 0, 0, 1, 0);
    add(10, 1, 1, 0, 1, 1, 4, 4, 8, 0, 1);
    add(16, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(17, 1, 1, 0, 1, 2, 2, 0, 0, 1, 0);
    add(18, 1, 1, 0, 1, 2, 2, 4, 8, 0, 1);
    add(25, 1, 1, 0, 1, 3, 1, 0, 0, 1, 0);
    add(26, 1, 1, 0, 1, 3, 1, 4, 8, 0, 1);
    add(32, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(33, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(34, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    i_reset = 1'b0;
    @(negedge clock);

    // Table-driven full run, cfg=0
    i_start = 1'b1; i_point_configuration = 3'd0; i_issue_ready = 1'b1;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clock);
      i_start = 1'b0;
      foreach (vq[i]) begin
        if (vq[i].j == j) begin
          chk($sformatf("run0.valid@%0d", j), 32'(o_issue_valid), 32'(vq[i].v));
          chk($sformatf("run0.busy@%0d", j),  32'(o_busy), 32'(vq[i].b));
          chk($sformatf("run0.done@%0d", j),  32'(o_done), 32'(vq[i].d));
          if (vq[i].f) begin
            chk($sformatf("run0.stage@%0d", j),  32'(o_stage), 32'(vq[i].st));
            chk($sformatf("run0.stride@%0d", j), 32'(o_stride), 32'(vq[i].sd));
            chk($sformatf("run0.k@%0d", j),      32'(o_bfly_index), 32'(vq[i].k));
            chk($sformatf("run0.top@%0d", j),    32'(o_addr_top), 32'(vq[i].top));
            chk($sformatf("run0.new@%0d", j),    32'(o_new_stage), 32'(vq[i].ns));
            chk($sformatf("run0.last@%0d", j),   32'(o_last_issue), 32'(vq[i].li));
          end
        end
      end
    end

    // Back-pressure: ready low for 3 cycles while k=4 of stage 0 is offered
    @(negedge clock);
    i_start = 1'b1; i_point_configuration = 3'd0; i_issue_ready = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
    chk("stall.k@1", 32'(o_bfly_index), 0);
    @(negedge clock);
    chk("stall.k@2", 32'(o_bfly_index), 4);
    i_issue_ready = 1'b0;
    for (int j = 3; j <= 5; j++) begin
      @(negedge clock);
      chk($sformatf("stall.valid@%0d", j), 32'(o_issue_valid), 1);
      chk($sformatf("stall.k@%0d", j),     32'(o_bfly_index), 4);
      chk($sformatf("stall.top@%0d", j),   32'(o_addr_top), 4);
      chk($sformatf("stall.last@%0d", j),  32'(o_last_issue), 1);
    end
    i_issue_ready = 1'b1;
    for (int j = 6; j <= 37; j++) begin
      @(negedge clock);
      if (j == 35) chk("stall.done@35", 32'(o_done), 0);
      if (j == 36) begin
        chk("stall.done@36", 32'(o_done), 1);
        chk("stall.count", 32'(o_stall_cycles), 32'(exp_stall));
      end
      if (j == 37) chk("stall.busy@37", 32'(o_busy), 0);
    end

    // Rejected configuration
    @(negedge clock);
    i_start = 1'b1; i_point_configuration = 3'd6;
    @(negedge clock);
    i_start = 1'b0;
    chk("cfg6.err@1",   32'(o_cfg_err), 1);
    chk("cfg6.busy@1",  32'(o_busy), 0);
    chk("cfg6.valid@1", 32'(o_issue_valid), 0);
    @(negedge clock);
    chk("cfg6.err@2",   32'(o_cfg_err), 0);
    chk("cfg6.busy@2",  32'(o_busy), 0);

    // Abort and start together in IDLE: start is dropped
    i_start = 1'b1; i_abort = 1'b1; i_point_configuration = 3'd0;
    @(negedge clock);
    i_start = 1'b0; i_abort = 1'b0;
    chk("absta.busy",  32'(o_busy), 0);
    chk("absta.valid", 32'(o_issue_valid), 0);

    // cfg=2, abort in the drain of stage 1
    @(negedge clock);
    i_start = 1'b1; i_point_configuration = 3'd2;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clock);
      i_start = 1'b0;
      if (j == 8) begin
        chk("c2.k@8",      32'(o_bfly_index), 28);
        chk("c2.top@8",    32'(o_addr_top), 28);
        chk("c2.stride@8", 32'(o_stride), 32);
        chk("c2.last@8",   32'(o_last_issue), 1);
      end
      if (j == 15) begin
        chk("c2.stage@15",  32'(o_stage), 1);
        chk("c2.stride@15", 32'(o_stride), 16);
        chk("c2.new@15",    32'(o_new_stage), 1);
      end
      if (j == 24) begin
        chk("c2.valid@24", 32'(o_issue_valid), 0);
        chk("c2.busy@24",  32'(o_busy), 1);
        chk("c2.stage@24", 32'(o_stage), 1);
        i_abort = 1'b1;
      end
    end
    @(negedge clock);
    i_abort = 1'b0;
    chk("abort.busy",  32'(o_busy), 0);
    chk("abort.valid", 32'(o_issue_valid), 0);
    done_seen = o_done;
    for (int j = 26; j <= 45; j++) begin
      @(negedge clock);
      done_seen = done_seen | o_done;
    end
    chk("abort.nodone", 32'(done_seen), 0);

    // Restart with cfg=1 after the abort
    i_start = 1'b1; i_point_configuration = 3'd1;
    @(negedge clock);
    i_start = 1'b0;
    chk("c1.valid",  32'(o_issue_valid), 1);
    chk("c1.stage",  32'(o_stage), 0);
    chk("c1.stride", 32'(o_stride), 16);
    chk("c1.k",      32'(o_bfly_index), 0);
    chk("c1.new",    32'(o_new_stage), 1);
    @(negedge clock);
    chk("c1.k@2",    32'(o_bfly_index), 4);

    // Asynchronous reset between edges while issuing
    #2 i_reset = 1'b1;
    #1;
    chk_all_zero("areset");
    @(negedge clock);
    i_reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("postrst.busy",  32'(o_busy), 0);
    chk("postrst.valid", 32'(o_issue_valid), 0);

    // Largest legal configuration is accepted; abort during ISSUE
    i_start = 1'b1; i_point_configuration = 3'd5;
    @(negedge clock);
    i_start = 1'b0;
    chk("c5.valid",  32'(o_issue_valid), 1);
    chk("c5.stride", 32'(o_stride), 256);
    chk("c5.err",    32'(o_cfg_err), 0);
    i_abort = 1'b1;
    @(negedge clock);
    i_abort = 1'b0;
    chk("c5.abort.busy", 32'(o_busy), 0);
    chk("c5.abort.done", 32'(o_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
